jtkiwi_shr_arb: RTL
===================

JTKIWI_SHR_ARB -- requirements
Module: jtkiwi_shr_arb

Interface
REQ-001 SHALL have parameter AW, default 13, meaning shared-RAM address width (8 kB).
REQ-002 SHALL have parameter DW, default 8, meaning data width.
REQ-003 SHALL have port clk, input, 1, single clock (24 MHz domain); all logic on its rising edge.
REQ-004 SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have ports m_cs/m_we, m_addr, m_din: input, 1/1, AW, DW; the main CPU request.
REQ-006 SHALL have ports m_dout, output, DW, and m_ok, output, 1; the main CPU response.
REQ-007 SHALL have ports s_cs/s_we, s_addr, s_din, s_dout, s_ok, same widths; the sub CPU requester.
REQ-008 SHALL have ports ram_addr, ram_din, ram_we, outputs, AW/DW/1; and ram_dout, input, DW.
- The RAM is synchronous with 1-cycle read latency.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-010 IDLE: SHALL grant a pending eligible requester and register its addr/din/we into ram_* on the same edge, then go to ACCESS.
REQ-011 ACCESS: ram_we SHALL equal the granted we for exactly this one cycle; the next state is DONE.
REQ-012 DONE: SHALL register ram_dout into the granted port's dout, pulse its ok for exactly one cycle, return to IDLE.
REQ-013 Latency: cs sampled high in IDLE -> ok high 3 cycles later (cycles 0, 1, 2, ok on cycle 3 edge output).
REQ-014 Eligibility: a port SHALL be eligible when cs=1 and its served flag=0.
- The served flag is set with ok.
- It is cleared when cs is sampled 0.
- Consequence: one access per cs assertion.
REQ-015 Simultaneous eligible requests SHALL use round-robin; the last-granted port loses.
REQ-016 A lone eligible request SHALL be granted regardless of priority pointer.
REQ-017 Non-granted port's dout SHALL hold its previous value; its ok SHALL stay 0.
REQ-018 cs drop during ACCESS/DONE SHALL abort: no ok pulse, no dout update, FSM returns IDLE next cycle.
- A write already in ACCESS stays committed.
REQ-019 ram_we SHALL be 0 in IDLE and DONE; no RAM write outside ACCESS.
REQ-020 Requester addr/din/we changes after grant SHALL be ignored; registered values are used.
REQ-021 Back-to-back: after DONE the FSM SHALL be able to grant the other port in the immediately following IDLE cycle.
- Worst-case wait for one port is 6 cycles.

Reset
REQ-022 While rstn=0, SHALL hold:
- FSM=IDLE
- m_ok=s_ok=0
- m_dout=s_dout=0
- ram_we=0, ram_addr=0, ram_din=0
- served flags=0
- priority pointer=main
REQ-023 rstn assertion mid-access SHALL abandon it immediately (asynchronous); no ok is generated after release.
REQ-024 The first request after rstn rises SHALL be granted on the first clk edge with cs high.

Structure
REQ-025 The FSM state encoding and port-index constants SHALL live in shared package jtkiwi_pkg.
REQ-026 Per-port served-flag/dout/ok logic SHALL be sub-module jtkiwi_shr_port, instantiated twice (main, sub).
REQ-027 Arbitration and FSM SHALL remain in jtkiwi_shr_arb; no additional clocks, no combinational path cs->ok.

Verification
REQ-028 Single read: RAM[0x0123]=0x5A, m_cs=1, m_we=0, m_addr=0x0123 -> m_ok one cycle at cycle 3, m_dout=0x5A, s_ok=0.
REQ-029 Single write: s_cs=1, s_we=1, s_addr=0x1FFF, s_din=0xC3 -> ram_we high exactly one cycle with ram_addr=0x1FFF, ram_din=0xC3; s_ok at cycle 3.
REQ-030 Contention: m_cs and s_cs both rise same cycle after reset -> main served first (ok cycle 3), sub ok cycle 6; repeat with both re-asserted -> sub first.
REQ-031 Held cs: m_cs held high 20 cycles -> exactly one m_ok pulse; drop cs one cycle, re-raise -> second access served.
REQ-032 Abort: s_cs drops in ACCESS cycle of a read -> no s_ok, s_dout unchanged, pending m_cs granted next IDLE.
REQ-033 Reset: rstn pulsed low during ACCESS of a write -> all outputs 0 immediately; after release m_ok stays 0 until a new m_cs.

Source files
------------

// File: rtl/jtkiwi_pkg.sv
// Shared definitions for the shared-RAM arbiter.
//   shr_state_t : arbiter FSM state encoding
//   PORT_MAIN / PORT_SUB : requester index used for grant and priority
//   rr_pick()   : round-robin choice between the two requesters
package jtkiwi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } shr_state_t;

  localparam logic PORT_MAIN = 1'b0;
  localparam logic PORT_SUB  = 1'b1;

  // With both ports eligible the priority pointer decides; otherwise the
  // single eligible port wins whatever the pointer says.
  function automatic logic rr_pick(input logic elig_m, input logic elig_s,
                                   input logic prio);
    if (elig_m && elig_s) return prio;
    return elig_s ? PORT_SUB : PORT_MAIN;
  endfunction

endpackage

// File: rtl/jtkiwi_shr_port.sv
// Per-requester response logic for the shared-RAM arbiter.
//   clk, rstn    : clock, asynchronous active-low reset
//   i_cs         : requester chip select
//   i_done       : completion strobe from the arbiter (DONE, granted, cs high)
//   i_ram_dout   : RAM read data, valid while i_done is high
//   o_dout, o_ok : registered read data and one-cycle acknowledge
//   o_served     : set with o_ok, cleared when cs is sampled low; blocks a
//                  second access within one cs assertion
module jtkiwi_shr_port #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_cs,
  input  logic          i_done,
  input  logic [DW-1:0] i_ram_dout,
  output logic [DW-1:0] o_dout,
  output logic          o_ok,
  output logic          o_served
);

  logic [DW-1:0] r_dout;
  logic          r_ok;
  logic          r_served;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dout   <= '0;
      r_ok     <= 1'b0;
      r_served <= 1'b0;
    end else begin
      r_ok <= i_done;
      if (i_done) r_dout <= i_ram_dout;
      if (!i_cs)       r_served <= 1'b0;
      else if (i_done) r_served <= 1'b1;
    end
  end

  assign o_dout   = r_dout;
  assign o_ok     = r_ok;
  assign o_served = r_served;

endmodule

// File: rtl/jtkiwi_shr_arb.sv
// Two-requester arbiter for a synchronous shared RAM (1-cycle read latency).
//   clk, rstn                         : clock, asynchronous active-low reset
//   m_cs/m_we/m_addr/m_din/m_dout/m_ok : main CPU port
//   s_cs/s_we/s_addr/s_din/s_dout/s_ok : sub CPU port
//   ram_addr/ram_din/ram_we, ram_dout  : RAM interface
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | pick an eligible requester, register its addr/din/we
// ST_ACCESS | ram_we driven for this single cycle; RAM samples address
// ST_DONE   | ram_dout valid; granted port captures it and pulses ok
module jtkiwi_shr_arb
  import jtkiwi_pkg::*;
#(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          m_cs,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_din,
  output logic [DW-1:0] m_dout,
  output logic          m_ok,
  input  logic          s_cs,
  input  logic          s_we,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_din,
  output logic [DW-1:0] s_dout,
  output logic          s_ok,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  shr_state_t r_state, w_state_nxt;
  logic       r_gnt;
  logic       r_prio;
  logic       w_served_m, w_served_s;
  logic       w_elig_m, w_elig_s;
  logic       w_pick, w_grant, w_gnt_cs;
  logic       w_done_m, w_done_s;

  assign w_elig_m = m_cs & ~w_served_m;
  assign w_elig_s = s_cs & ~w_served_s;
  assign w_pick   = rr_pick(w_elig_m, w_elig_s, r_prio);
  assign w_gnt_cs = (r_gnt == PORT_SUB) ? s_cs : m_cs;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A granted port dropping cs in ACCESS or DONE aborts the transaction:
  // back to IDLE without a completion strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done_m    = 1'b0;
    w_done_s    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_elig_m || w_elig_s) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: w_state_nxt = w_gnt_cs ? ST_DONE : ST_IDLE;
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_done_m    = w_gnt_cs & (r_gnt == PORT_MAIN);
        w_done_s    = w_gnt_cs & (r_gnt == PORT_SUB);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The priority pointer only moves on a contended grant, so a lone access
  // in between does not change who wins the next tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gnt    <= PORT_MAIN;
      r_prio   <= PORT_MAIN;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
    end else if (w_grant) begin
      r_gnt    <= w_pick;
      ram_addr <= (w_pick == PORT_SUB) ? s_addr : m_addr;
      ram_din  <= (w_pick == PORT_SUB) ? s_din  : m_din;
      ram_we   <= (w_pick == PORT_SUB) ? s_we   : m_we;
      if (w_elig_m && w_elig_s) r_prio <= ~w_pick;
    end else begin
      ram_we <= 1'b0;
    end
  end

  jtkiwi_shr_port #(.DW(DW)) u_port_main (
    .clk        (clk),
    .rstn       (rstn),
    .i_cs       (m_cs),
    .i_done     (w_done_m),
    .i_ram_dout (ram_dout),
    .o_dout     (m_dout),
    .o_ok       (m_ok),
    .o_served   (w_served_m)
  );

  jtkiwi_shr_port #(.DW(DW)) u_port_sub (
    .clk        (clk),
    .rstn       (rstn),
    .i_cs       (s_cs),
    .i_done     (w_done_s),
    .i_ram_dout (ram_dout),
    .o_dout     (s_dout),
    .o_ok       (s_ok),
    .o_served   (w_served_s)
  );

endmodule
